aoram_banked_ctrl: RTL and testbench

// - Parametrised successor of the always-on RAM front end. It sits between the SRAM controller

---
 rtl/aoram_pkg.sv | 12 +
 rtl/aoram_banked_ctrl_if.sv | 24 ++
 rtl/aoram_bank_pwr.sv | 48 ++++
 rtl/aoram_banked_ctrl.sv | 129 ++++++++++++
 tb/tb_aoram_banked_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/aoram_pkg.sv
// Shared types and helpers for the banked always-on RAM front end.
package aoram_pkg;

  typedef enum logic [1:0] {AWAKE, SLEEP, WAKING} aoram_bank_st_e;

  typedef enum logic [1:0] {Z_IDLE, Z_WAKE, Z_WALK} aoram_zero_st_e;

  function automatic int bsw(input int nb);
    return $clog2(nb);
  endfunction

endpackage

// File: rtl/aoram_banked_ctrl_if.sv
// Request/response bus between the SRAM controller master port and the AO RAM front end.
interface aoram_banked_ctrl_if #(
  parameter int AW  = 11,
  parameter int DW0 = 36,
  parameter int BC  = 4
);
  logic           req_cs;
  logic [AW-1:0]  req_addr;
  logic [BC-1:0]  req_wr;
  logic [DW0-1:0] req_wdata;
  logic           req_ready;
  logic           rsp_valid;
  logic [DW0-1:0] rsp_rdata;

  modport master (
    output req_cs, req_addr, req_wr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_cs, req_addr, req_wr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/aoram_bank_pwr.sv
// Per-bank sleep/retention sequencer: AWAKE -> SLEEP -> WAKING -> AWAKE with a wake delay counter.
module aoram_bank_pwr import aoram_pkg::*; #(
  parameter int WAKECYC = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           sleep_req,
  input  logic           access,
  input  logic           force_wake,
  output aoram_bank_st_e state,
  output logic           ret
);
  localparam int CW = $clog2(WAKECYC + 1);
  localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKECYC);

  aoram_bank_st_e state_reg;
  logic [CW-1:0]  cnt_reg;
  logic           ret_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= AWAKE;
      cnt_reg   <= '0;
      ret_reg   <= 1'b0;
    end else begin
      case (state_reg)
        AWAKE: if (sleep_req && !access && !force_wake) begin
          state_reg <= SLEEP;
          ret_reg   <= 1'b1;
        end
        SLEEP: if (!sleep_req || access || force_wake) begin
          state_reg <= WAKING;
          ret_reg   <= 1'b0;
          cnt_reg   <= WAKE_LOAD;
        end
        // A sleep request while waking is ignored; the bank re-sleeps from AWAKE.
        WAKING: begin
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CW'(1)) state_reg <= AWAKE;
        end
        default: state_reg <= AWAKE;
      endcase
    end
  end

  assign state = state_reg;
  assign ret   = ret_reg;
endmodule

// File: rtl/aoram_banked_ctrl.sv
// Banked AO SRAM front end: bank decode, byte-lane writes, per-bank power sequencing, zeroize engine.
module aoram_banked_ctrl import aoram_pkg::*; #(
  parameter int NB          = 2,
  parameter int AW          = 11,
  parameter int DW          = 32,
  parameter int PW          = 4,
  parameter int BW          = 9,
  parameter int WAKECYC     = 4,
  parameter int ZERO_ON_RST = 1,
  localparam int BSW = bsw(NB),
  localparam int AW0 = AW - BSW,
  localparam int DW0 = DW + PW,
  localparam int BC  = DW0 / BW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmsatpg,
  aoram_banked_ctrl_if.slave     bus,
  input  logic [NB-1:0]          bank_sleep_req,
  output logic [NB-1:0]          bank_awake,
  input  logic                   zero_start,
  output logic                   zero_busy,
  output logic [NB-1:0]          ram_clken,
  output logic [NB-1:0]          ram_cen,
  output logic [NB-1:0]          ram_gwen,
  output logic [BC*BW-1:0]       ram_wen,
  output logic [NB-1:0]          ram_ret,
  output logic [AW0-1:0]         ram_a,
  output logic [DW0-1:0]         ram_d,
  input  logic [NB*DW0-1:0]      ram_q
);
  genvar gi;

  logic [BSW-1:0]  sel;
  logic [AW0-1:0]  local_addr;
  logic [NB-1:0]   bank_hit;
  logic [BC*BW-1:0] lane_wen;
  aoram_bank_st_e  bank_st [NB];

  aoram_zero_st_e  z_st_reg;
  logic [AW0-1:0]  z_addr_reg;
  logic            first_reg;
  logic            rsp_valid_reg;
  logic [BSW-1:0]  sel_reg;

  logic zero_go, walk, accept, is_write, all_awake;

  assign sel        = bus.req_addr[AW-1:AW0];
  assign local_addr = bus.req_addr[AW0-1:0];
  assign all_awake  = &bank_awake;
  assign zero_busy  = (z_st_reg != Z_IDLE);
  assign walk       = (z_st_reg == Z_WALK);
  // The auto-start cycle after reset behaves exactly like a zero_start pulse.
  assign zero_go    = (z_st_reg == Z_IDLE) && (zero_start || ((ZERO_ON_RST != 0) && first_reg));
  assign is_write   = |bus.req_wr;

  assign bus.req_ready = !reset && bank_awake[sel] && !zero_busy && !zero_go;
  assign accept        = bus.req_cs && bus.req_ready;

  for (gi = 0; gi < NB; gi++) begin : g_bank
    aoram_bank_pwr #(.WAKECYC(WAKECYC)) u_pwr (
      .clk        (clk),
      .reset      (reset),
      .sleep_req  (bank_sleep_req[gi]),
      .access     (bus.req_cs && (sel == BSW'(gi))),
      .force_wake (zero_busy || zero_go),
      .state      (bank_st[gi]),
      .ret        (ram_ret[gi])
    );
    assign bank_awake[gi] = (bank_st[gi] == AWAKE);
    assign bank_hit[gi]   = accept && (sel == BSW'(gi));
  end

  for (gi = 0; gi < BC; gi++) begin : g_lane
    assign lane_wen[gi*BW +: BW] = {BW{~bus.req_wr[gi]}};
  end

  always_comb begin
    ram_cen   = '1;
    ram_gwen  = '1;
    ram_wen   = '1;
    ram_a     = '0;
    ram_d     = '0;
    ram_clken = '0;
    if (walk) begin
      ram_cen   = '0;
      ram_gwen  = '0;
      ram_wen   = '0;
      ram_a     = z_addr_reg;
      ram_clken = '1;
    end else if (accept) begin
      ram_cen   = ~bank_hit;
      ram_clken = bank_hit;
      ram_a     = local_addr;
      if (is_write) begin
        ram_gwen = ~bank_hit;
        ram_wen  = lane_wen;
        ram_d    = bus.req_wdata;
      end
    end
    if (cmsatpg) ram_clken = '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      z_st_reg      <= Z_IDLE;
      z_addr_reg    <= '0;
      first_reg     <= 1'b1;
      rsp_valid_reg <= 1'b0;
      sel_reg       <= '0;
    end else begin
      first_reg     <= 1'b0;
      rsp_valid_reg <= accept && !is_write;
      if (accept && !is_write) sel_reg <= sel;
      case (z_st_reg)
        Z_IDLE: if (zero_go) z_st_reg <= all_awake ? Z_WALK : Z_WAKE;
        Z_WAKE: if (all_awake) z_st_reg <= Z_WALK;
        Z_WALK: begin
          z_addr_reg <= z_addr_reg + 1'b1;
          if (&z_addr_reg) z_st_reg <= Z_IDLE;
        end
        default: z_st_reg <= Z_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_valid_reg ? ram_q[sel_reg*DW0 +: DW0] : '0;
endmodule

// File: tb/tb_aoram_banked_ctrl.sv
// Directed bench for aoram_banked_ctrl with a behavioural two-bank SRAM model.
module tb_aoram_banked_ctrl;
  localparam int NB = 2, AW = 11, AW0 = 10, DW0 = 36, BC = 4, BW = 9, WAKECYC = 4;
  localparam int DEPTH = 1 << AW0;

  logic clk = 1'b0;
  logic reset, cmsatpg, zero_start, zero_busy, mem_fill;
  logic [NB-1:0] bank_sleep_req, bank_awake, ram_clken, ram_cen, ram_gwen, ram_ret;
  logic [BC*BW-1:0] ram_wen;
  logic [AW0-1:0] ram_a;
  logic [DW0-1:0] ram_d;
  logic [NB*DW0-1:0] ram_q;
  logic [DW0-1:0] mem [NB][DEPTH];
  int total = 0, bad = 0;

  aoram_banked_ctrl_if #(.AW(AW), .DW0(DW0), .BC(BC)) bus ();

  aoram_banked_ctrl dut (
    .clk(clk), .reset(reset), .cmsatpg(cmsatpg), .bus(bus),
    .bank_sleep_req(bank_sleep_req), .bank_awake(bank_awake),
    .zero_start(zero_start), .zero_busy(zero_busy),
    .ram_clken(ram_clken), .ram_cen(ram_cen), .ram_gwen(ram_gwen), .ram_wen(ram_wen),
    .ram_ret(ram_ret), .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Single-port SRAM banks: bit-masked write, registered read.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (mem_fill) begin
        for (int k = 0; k < DEPTH; k++) mem[b][k] <= 36'h5_A5A5_A5A5;
      end else if (!ram_cen[b]) begin
        if (!ram_gwen[b]) mem[b][ram_a] <= (mem[b][ram_a] & ram_wen) | (ram_d & ~ram_wen);
        else ram_q[b*DW0 +: DW0] <= mem[b][ram_a];
      end
    end
  end

  task automatic drive(input logic cs, input logic [AW-1:0] addr, input logic [BC-1:0] wr,
                       input logic [DW0-1:0] wd);
    @(negedge clk);
    bus.req_cs = cs; bus.req_addr = addr; bus.req_wr = wr; bus.req_wdata = wd;
    if (cs) $display("txn %s addr=%h wr=%b wdata=%h", (wr != 0) ? "write" : "read", addr, wr, wd);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    mem_fill = 1'b0;
    total++; if ({ram_cen, ram_gwen, ram_clken, ram_ret, bank_awake} !== 10'b11_11_00_00_11) begin
      bad++; $display("FAIL rst_bank_ctl got=%b want=1111000011", {ram_cen, ram_gwen, ram_clken, ram_ret, bank_awake}); end
    total++; if (ram_wen !== '1) begin bad++; $display("FAIL rst_wen got=%h want=fffffffff", ram_wen); end
    total++; if ({ram_a, ram_d} !== '0) begin bad++; $display("FAIL rst_a_d got=%h/%h want=0/0", ram_a, ram_d); end
    total++; if ({bus.req_ready, bus.rsp_valid, zero_busy} !== 3'b000) begin
      bad++; $display("FAIL rst_flags got=%b want=000", {bus.req_ready, bus.rsp_valid, zero_busy}); end
    total++; if (bus.rsp_rdata !== '0) begin bad++; $display("FAIL rst_rdata got=%h want=0", bus.rsp_rdata); end
    cmsatpg = 1'b1; #1;
    total++; if (ram_clken !== 2'b11) begin bad++; $display("FAIL rst_scan_clken got=%b want=11", ram_clken); end
    cmsatpg = 1'b0; #1;
  endtask

  task automatic test_zero_on_rst;
    int n, errs;
    @(negedge clk);
    reset = 1'b0; bus.req_cs = 1'b1; bus.req_addr = '0; bus.req_wr = '0; #1;
    total++; if (bus.req_ready !== 1'b0 || ram_cen !== 2'b11) begin
      bad++; $display("FAIL zrst_start_stall got ready=%b cen=%b want 0/11", bus.req_ready, ram_cen); end
    total++; if (zero_busy !== 1'b0) begin bad++; $display("FAIL zrst_busy_start got=%b want=0", zero_busy); end
    bus.req_cs = 1'b0;
    n = 0; errs = 0;
    @(negedge clk); #1;
    while (zero_busy === 1'b1 && n < 2000) begin
      if (ram_cen !== 2'b00 || ram_gwen !== 2'b00 || ram_wen !== '0 || ram_d !== '0 || ram_a !== n[AW0-1:0]) errs++;
      n++; @(negedge clk); #1;
    end
    total++; if (n !== DEPTH) begin bad++; $display("FAIL zrst_walk_len got=%0d want=%0d", n, DEPTH); end
    total++; if (errs !== 0) begin bad++; $display("FAIL zrst_walk_pins got=%0d bad cycles want=0", errs); end
    drive(1'b1, 11'h7FF, 4'b0000, '0);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL zrst_rd_ready got=%b want=1", bus.req_ready); end
    drive(1'b0, '0, '0, '0);
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== '0) begin
      bad++; $display("FAIL zrst_rd_7ff got=%b/%h want=1/000000000", bus.rsp_valid, bus.rsp_rdata); end
  endtask

  task automatic test_write_read;
    drive(1'b1, 11'h005, 4'b1111, 36'h9_DEADBEEF);
    total++; if ({bus.req_ready, ram_cen, ram_gwen, ram_clken} !== 7'b1_10_10_01) begin
      bad++; $display("FAIL wr_ctl got=%b want=1101001", {bus.req_ready, ram_cen, ram_gwen, ram_clken}); end
    total++; if (ram_wen !== '0 || ram_a !== 10'h005 || ram_d !== 36'h9_DEADBEEF) begin
      bad++; $display("FAIL wr_bus got wen=%h a=%h d=%h want 0/005/9deadbeef", ram_wen, ram_a, ram_d); end
    drive(1'b1, 11'h005, 4'b0000, '0);
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_no_rsp got=%b want=0", bus.rsp_valid); end
    total++; if ({ram_cen, ram_gwen} !== 4'b10_11) begin bad++; $display("FAIL rd_ctl got=%b want=1011", {ram_cen, ram_gwen}); end
    drive(1'b0, '0, '0, '0);
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 36'h9_DEADBEEF) begin
      bad++; $display("FAIL rd_full got=%b/%h want=1/9deadbeef", bus.rsp_valid, bus.rsp_rdata); end
    drive(1'b1, 11'h005, 4'b0001, '0);
    total++; if (ram_wen !== 36'hF_FFFF_FE00) begin bad++; $display("FAIL lane_wen got=%h want=ffffffe00", ram_wen); end
    drive(1'b1, 11'h005, 4'b0000, '0);
    drive(1'b0, '0, '0, '0);
    total++; if (bus.rsp_rdata !== 36'h9_DEADBE00) begin bad++; $display("FAIL rd_lane got=%h want=9deadbe00", bus.rsp_rdata); end
    drive(1'b0, '0, '0, '0);
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL idle_no_rsp got=%b want=0", bus.rsp_valid); end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 11'h000, 4'b1111, 36'h0_1111_1111);
    drive(1'b1, 11'h400, 4'b1111, 36'h1_2345_678A);
    drive(1'b1, 11'h001, 4'b1111, 36'h2_2222_2222);
    drive(1'b1, 11'h000, 4'b0000, '0);
    drive(1'b1, 11'h400, 4'b0000, '0);
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 36'h0_1111_1111) begin
      bad++; $display("FAIL b2b_beat0 got=%b/%h want=1/011111111", bus.rsp_valid, bus.rsp_rdata); end
    total++; if (ram_cen !== 2'b01 || ram_a !== 10'h000) begin
      bad++; $display("FAIL b2b_bank1_sel got cen=%b a=%h want 01/000", ram_cen, ram_a); end
    drive(1'b1, 11'h001, 4'b0000, '0);
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 36'h1_2345_678A) begin
      bad++; $display("FAIL b2b_beat1 got=%b/%h want=1/12345678a", bus.rsp_valid, bus.rsp_rdata); end
    drive(1'b0, '0, '0, '0);
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 36'h2_2222_2222) begin
      bad++; $display("FAIL b2b_beat2 got=%b/%h want=1/222222222", bus.rsp_valid, bus.rsp_rdata); end
  endtask

  task automatic test_sleep_wake;
    int n;
    @(negedge clk); bank_sleep_req = 2'b10; #1;
    @(negedge clk); #1;
    total++; if (ram_ret !== 2'b10 || bank_awake !== 2'b01) begin
      bad++; $display("FAIL sleep_enter got ret=%b awake=%b want 10/01", ram_ret, bank_awake); end
    drive(1'b1, 11'h400, 4'b0000, '0);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      n++; @(negedge clk); #1;
      if (n == 1) begin
        total++; if (ram_ret !== 2'b00) begin bad++; $display("FAIL wake_ret got=%b want=00", ram_ret); end
      end
    end
    total++; if (n !== 1 + WAKECYC) begin bad++; $display("FAIL wake_stall got=%0d want=%0d", n, 1 + WAKECYC); end
    drive(1'b0, '0, '0, '0);
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 36'h1_2345_678A) begin
      bad++; $display("FAIL wake_data got=%b/%h want=1/12345678a", bus.rsp_valid, bus.rsp_rdata); end
    @(negedge clk); #1;
    total++; if (ram_ret !== 2'b10) begin bad++; $display("FAIL resleep got=%b want=10", ram_ret); end
  endtask

  task automatic test_zero_sleep;
    int n, errs, pre, busy_n;
    @(negedge clk); bank_sleep_req = 2'b01; #1;
    repeat (WAKECYC + 2) @(negedge clk);
    #1;
    total++; if (bank_awake !== 2'b10 || ram_ret !== 2'b01) begin
      bad++; $display("FAIL zs_setup got awake=%b ret=%b want 10/01", bank_awake, ram_ret); end
    @(negedge clk);
    zero_start = 1'b1; bus.req_cs = 1'b1; bus.req_addr = 11'h400; bus.req_wr = '0; #1;
    total++; if (bus.req_ready !== 1'b0 || ram_cen !== 2'b11) begin
      bad++; $display("FAIL zs_wins got ready=%b cen=%b want 0/11", bus.req_ready, ram_cen); end
    @(negedge clk); zero_start = 1'b0; bus.req_cs = 1'b0; #1;
    total++; if (zero_busy !== 1'b1 || ram_ret !== 2'b00) begin
      bad++; $display("FAIL zs_force_wake got busy=%b ret=%b want 1/00", zero_busy, ram_ret); end
    n = 0; errs = 0; pre = 0; busy_n = 0;
    while (zero_busy === 1'b1 && busy_n < 3000) begin
      if (ram_cen === 2'b00) begin
        if (bank_awake !== 2'b11 || ram_a !== n[AW0-1:0]) errs++;
        n++;
      end else pre++;
      busy_n++; @(negedge clk); #1;
    end
    total++; if (n !== DEPTH || errs !== 0) begin
      bad++; $display("FAIL zs_walk got len=%0d errs=%0d want %0d/0", n, errs, DEPTH); end
    total++; if (pre < WAKECYC) begin bad++; $display("FAIL zs_wake_wait got=%0d want>=%0d", pre, WAKECYC); end
    total++; if (ram_ret !== 2'b00) begin bad++; $display("FAIL zs_sleep_held got=%b want=00", ram_ret); end
    @(negedge clk); #1;
    total++; if (ram_ret !== 2'b01) begin bad++; $display("FAIL zs_sleep_after got=%b want=01", ram_ret); end
    drive(1'b1, 11'h400, 4'b0000, '0);
    drive(1'b0, '0, '0, '0);
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== '0) begin
      bad++; $display("FAIL zs_cleared got=%b/%h want=1/000000000", bus.rsp_valid, bus.rsp_rdata); end
  endtask

  task automatic test_reset_abort;
    int n;
    @(negedge clk); bank_sleep_req = 2'b00; #1;
    repeat (WAKECYC + 2) @(negedge clk);
    @(negedge clk); zero_start = 1'b1; #1;
    @(negedge clk); zero_start = 1'b0; #1;
    n = 0;
    while (!(ram_cen === 2'b00 && ram_a === 10'd100) && n < 500) begin n++; @(negedge clk); #1; end
    total++; if (n >= 500) begin bad++; $display("FAIL ab_reach100 got=%0d cycles want<500", n); end
    reset = 1'b1;
    @(negedge clk); #1;
    total++; if ({ram_cen, ram_gwen, ram_clken, ram_ret, bank_awake} !== 10'b11_11_00_00_11) begin
      bad++; $display("FAIL ab_bank_ctl got=%b want=1111000011", {ram_cen, ram_gwen, ram_clken, ram_ret, bank_awake}); end
    total++; if (ram_wen !== '1 || ram_a !== '0 || ram_d !== '0) begin
      bad++; $display("FAIL ab_pins got wen=%h a=%h d=%h want fffffffff/0/0", ram_wen, ram_a, ram_d); end
    total++; if ({bus.req_ready, bus.rsp_valid, zero_busy} !== 3'b000 || bus.rsp_rdata !== '0) begin
      bad++; $display("FAIL ab_flags got=%b rdata=%h want=000/0", {bus.req_ready, bus.rsp_valid, zero_busy}, bus.rsp_rdata); end
    reset = 1'b0; #1;
    total++; if (zero_busy !== 1'b0 || bus.req_ready !== 1'b0) begin
      bad++; $display("FAIL ab_restart_cycle got busy=%b ready=%b want 0/0", zero_busy, bus.req_ready); end
    @(negedge clk); #1;
    total++; if (zero_busy !== 1'b1 || ram_cen !== 2'b00 || ram_a !== '0) begin
      bad++; $display("FAIL ab_restart_k0 got busy=%b cen=%b a=%h want 1/00/000", zero_busy, ram_cen, ram_a); end
    n = 0;
    while (zero_busy === 1'b1 && n < 2000) begin n++; @(negedge clk); #1; end
    total++; if (n !== DEPTH) begin bad++; $display("FAIL ab_full_walk got=%0d want=%0d", n, DEPTH); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=time_limit want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; cmsatpg = 1'b0; zero_start = 1'b0; bank_sleep_req = '0; mem_fill = 1'b1;
    bus.req_cs = 1'b0; bus.req_addr = '0; bus.req_wr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    test_reset;
    test_zero_on_rst;
    test_write_read;
    test_back_to_back;
    test_sleep_wake;
    test_zero_sleep;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
